// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// State encoding and default operand width.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int W_DEF = 8;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: operand shifters, 2W accumulator, step counter.
// Load clears and captures; step performs one add/shift iteration.
module mult_shift_add_dp
   import mult_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] acc_next,
   output logic           last
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;

   // Value the accumulator takes on this step; never wraps at 2W bits.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   // The step in progress is the W-th one.
   assign last = (cnt == LAST_CNT);

   // Capture operands on load, otherwise iterate one bit per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_next;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential unsigned multiplier: fixed W-cycle shift-add run.
// FSM sequences the datapath and registers the final result.
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         START,
   input  logic [W-1:0] MULTIPLICAND,
   input  logic [W-1:0] MULTIPLIER,
   output logic         BUSY,
   output logic         DONE,
   output logic [W-1:0] OUT,
   output logic         OVERFLOW
);

   state_t         state;
   state_t         state_nxt;
   logic           load;
   logic           step;
   logic           last;
   logic [2*W-1:0] acc_next;

   mult_shift_add_dp #(.W(W)) u_dp (
      .clk      (CLK),
      .rst_n    (RESET),
      .load     (load),
      .step     (step),
      .a        (MULTIPLICAND),
      .b        (MULTIPLIER),
      .acc_next (acc_next),
      .last     (last)
   );

   // State register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: RUN always lasts W steps; FINISH may chain a new run.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (START) state_nxt = RUN;
         RUN:     if (last)  state_nxt = FINISH;
         FINISH:  state_nxt = START ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs and datapath enables.
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      load = 1'b0;
      step = 1'b0;
      unique case (state)
         IDLE:    load = START;
         RUN: begin
            BUSY = 1'b1;
            step = 1'b1;
         end
         FINISH: begin
            DONE = 1'b1;
            load = START;
         end
         default: ;
      endcase
   end

   // Result registers update only on the final step and hold otherwise.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         OUT      <= '0;
         OVERFLOW <= 1'b0;
      end else if (step && last) begin
         OUT      <= acc_next[W-1:0];
         OVERFLOW <= |acc_next[2*W-1:W];
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer at W=8.
// Hand-computed products, latency and reset-abort checks.
module tb_mult_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] out;
   logic         ovf;

   int nchk;
   int nerr;

   mult_sequencer #(.W(W)) dut (
      .CLK          (clk),
      .RESET        (rst_n),
      .START        (start),
      .MULTIPLICAND (a),
      .MULTIPLIER   (b),
      .BUSY         (busy),
      .DONE         (done),
      .OUT          (out),
      .OVERFLOW     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One op with START pulsed; counts BUSY cycles and edge of DONE.
   task automatic run_op(input string nm,
                         input logic [W-1:0] ia,
                         input logic [W-1:0] ib,
                         input logic [W-1:0] eo,
                         input logic eov);
      int busyc;
      int dedge;
      busyc = 0;
      dedge = 0;
      @(negedge clk);
      start = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~ia;
      b = ~ib;
      if (busy) busyc++;
      for (int i = 2; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dedge = i;
            break;
         end
         if (busy) busyc++;
      end
      chk({nm, " done_edge"}, dedge, 9);
      chk({nm, " busy_cycles"}, busyc, 8);
      chk({nm, " out"}, out, eo);
      chk({nm, " ovf"}, ovf, eov);
      @(posedge clk);
      #1;
      chk({nm, " done_pulse"}, done, 0);
      chk({nm, " out_hold"}, out, eo);
   endtask

   initial begin
      int dedge;
      logic seen;
      nchk = 0;
      nerr = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #12;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst out", out, 0);
      chk("rst ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op("3x2", 8'd3, 8'd2, 8'd6, 1'b0);
      run_op("16x16", 8'd16, 8'd16, 8'h00, 1'b1);
      run_op("255x255", 8'd255, 8'd255, 8'h01, 1'b1);
      run_op("0x200", 8'd0, 8'd200, 8'd0, 1'b0);
      run_op("15x17", 8'd15, 8'd17, 8'd255, 1'b0);

      // Back-to-back with START held and operands changed mid-run.
      @(negedge clk);
      start = 1'b1;
      a = 8'd7;
      b = 8'd5;
      @(posedge clk);
      #1;
      a = 8'd9;
      b = 8'd9;
      dedge = 0;
      for (int i = 2; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dedge = i;
            break;
         end
      end
      chk("b2b first_edge", dedge, 9);
      chk("b2b first_out", out, 35);
      @(posedge clk);
      #1;
      chk("b2b rerun_busy", busy, 1);
      chk("b2b rerun_done", done, 0);
      start = 1'b0;
      a = 8'd1;
      b = 8'd1;
      dedge = 0;
      for (int i = 2; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dedge = i;
            break;
         end
      end
      chk("b2b second_edge", dedge, 9);
      chk("b2b second_out", out, 81);
      chk("b2b second_ovf", ovf, 0);

      // Reset mid-run aborts without DONE.
      repeat (2) @(negedge clk);
      start = 1'b1;
      a = 8'd12;
      b = 8'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort out", out, 0);
      chk("abort ovf", ovf, 0);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      chk("abort no_done", seen, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("12x12", 8'd12, 8'd12, 8'd144, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port MULTIPLICAND, input, W bits: unsigned operand A.
REQ-006 The block SHALL have port MULTIPLIER, input, W bits: unsigned operand B.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port DONE, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port OUT, output, W bits: registered low W bits of A*B.
REQ-010 The block SHALL have port OVERFLOW, output, 1 bit: registered flag, high when bits [2W-1:W] of A*B are nonzero.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-012 In IDLE with START=1 at a rising edge, the block SHALL capture MULTIPLICAND and MULTIPLIER, clear the 2W-bit accumulator, zero the step counter and go to RUN.
REQ-013 In IDLE with START=0, the block SHALL remain in IDLE.
REQ-014 RUN SHALL last exactly W cycles; at each edge: if the multiplier-register LSB is 1, add the 2W-bit zero-extended shifted multiplicand to the accumulator; shift the multiplicand left 1; shift the multiplier right 1; increment the counter.
REQ-015 Latency SHALL be fixed at W cycles, with no early termination on a zero multiplier.
REQ-016 At the edge completing the W-th step, the block SHALL go to FINISH and load OUT=acc[W-1:0] and OVERFLOW=|acc[2W-1:W] (final accumulated value).
REQ-017 BUSY SHALL be 1 exactly while the state is RUN.
REQ-018 DONE SHALL be 1 exactly while the state is FINISH (one cycle).
REQ-019 In FINISH with START=1, the block SHALL capture new operands and enter RUN (back-to-back); with START=0 it SHALL enter IDLE.
REQ-020 START in RUN SHALL be ignored; operand inputs SHALL not affect an operation after capture.
REQ-021 OUT and OVERFLOW SHALL hold their value from one FINISH until the next FINISH.
REQ-022 The accumulator SHALL be 2W bits wide and SHALL never wrap for any unsigned operand pair.
REQ-023 START to DONE SHALL be W+1 rising edges, counting the capturing edge as edge 1.

Reset
REQ-024 RESET=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, OUT=0, OVERFLOW=0, accumulator=0, counter=0 and operand registers=0, independent of CLK.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse, leaving OUT at 0.
REQ-026 After RESET deasserts, the first START SHALL be honoured normally.

Structure
REQ-027 Package mult_pkg SHALL hold the state enumeration (IDLE, RUN, FINISH) and the default width constant (8).
REQ-028 Sub-module mult_shift_add_dp SHALL contain the operand shift registers, the accumulator and the counter, driven by load/step enables from the FSM in mult_sequencer.
REQ-029 The counter width SHALL be $clog2(W)+1 bits.

Verification
REQ-030 W=8, A=3, B=2, START pulsed once -> BUSY high 8 cycles, DONE pulses on edge 9, OUT=6, OVERFLOW=0.
REQ-031 A=16, B=16 -> OUT=0x00, OVERFLOW=1; A=255, B=255 -> OUT=0x01, OVERFLOW=1 (product 0xFE01).
REQ-032 A=0, B=200 -> OUT=0, OVERFLOW=0, still exactly 8 BUSY cycles.
REQ-033 START held high, with A/B changed during RUN, 7*5 then 9*9 back-to-back -> first DONE OUT=35, next RUN starts directly from FINISH, second DONE OUT=81; mid-RUN operand changes ignored.
REQ-034 RESET low after 4 RUN cycles of 12*12 -> all outputs 0 at once and no DONE; after release, 12*12 -> OUT=144, OVERFLOW=0.
